rc5_round_core: RTL and testbench

- Parametrised, iterative RC5-W/R/b datapath that encrypts or decrypts one two-word block per request, selected by a mode input.
- Successor to the fixed-width decipher-only DUT. Adds selectable word width, selectable round count, an encrypt/decrypt mode, and a start/busy/done handshake.
- Sits between the key-expansion unit (which owns the S table RAM) and the block-level control. Reads round keys through a synchronous read port, one per cycle.

---
 rtl/rc5_round_core.sv | 159 +++++++++++++++
 tb/tb_rc5_round_core.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc5_round_core.sv
// rc5_round_core: iterative RC5-W/R encrypt/decrypt datapath.
// One round-key word is fetched per cycle from an external synchronous S-table
// RAM; one half-round (one key index) is applied per cycle.
//
// Handshake: iStart is sampled only while IDLE, and iMode/iA/iB are latched on
// that same edge. oBusy is high from the cycle after acceptance until the
// result cycle. oDone pulses high for exactly one cycle, in which oA/oB carry
// the new result; oA/oB then hold until the next completion. A new iStart
// presented during the oDone cycle is accepted, so operations can run
// back-to-back with no bubble.
module rc5_round_core #(
  parameter int W   = 32,
  parameter int LGW = 5,
  parameter int R   = 12,
  parameter int AW  = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          iStart,
  input  logic          iMode,
  input  logic [W-1:0]  iA,
  input  logic [W-1:0]  iB,
  output logic [AW-1:0] oS_addr,
  input  logic [W-1:0]  iS_data,
  output logic [W-1:0]  oA,
  output logic [W-1:0]  oB,
  output logic          oBusy,
  output logic          oDone
);

  // Last key index (2R+1); also the last step number.
  localparam int            LAST      = 2 * R + 1;
  localparam logic [8:0]    STEP_LAST = 9'(LAST);
  localparam logic [AW-1:0] ADDR_LAST = AW'(LAST);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [W-1:0]  a_q, b_q;
  logic          mode_q;
  logic [8:0]    step_q;
  logic [8:0]    k;
  logic [W-1:0]  a_nx, b_nx;
  logic [AW-1:0] addr_adv;
  logic          accept, finish;

  function automatic logic [W-1:0] rol(input logic [W-1:0] x, input logic [LGW-1:0] n);
    logic [2*W-1:0] t;
    t = {x, x} << n;
    return t[2*W-1:W];
  endfunction

  function automatic logic [W-1:0] ror(input logic [W-1:0] x, input logic [LGW-1:0] n);
    logic [2*W-1:0] t;
    t = {x, x} >> n;
    return t[W-1:0];
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic and the accept/finish strobes.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    finish   = 1'b0;
    case (state)
      IDLE: begin
        if (iStart) begin
          accept   = 1'b1;
          state_nx = PRIME;
        end
      end
      PRIME: state_nx = RUN;
      RUN: begin
        if (step_q == STEP_LAST) begin
          finish   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Key index for the current step and the half-round it selects.
  always_comb begin
    k    = mode_q ? (STEP_LAST - step_q) : step_q;
    a_nx = a_q;
    b_nx = b_q;
    if (!mode_q) begin
      if (k == 9'd0)      a_nx = a_q + iS_data;
      else if (k == 9'd1) b_nx = b_q + iS_data;
      else if (!k[0])     a_nx = rol(a_q ^ b_q, b_q[LGW-1:0]) + iS_data;
      else                b_nx = rol(b_q ^ a_q, a_q[LGW-1:0]) + iS_data;
    end else begin
      if (k == 9'd0)      a_nx = a_q - iS_data;
      else if (k == 9'd1) b_nx = b_q - iS_data;
      else if (!k[0])     a_nx = ror(a_q - iS_data, b_q[LGW-1:0]) ^ b_q;
      else                b_nx = ror(b_q - iS_data, a_q[LGW-1:0]) ^ a_q;
    end
  end

  // Address walk, saturating at the last index in the walking direction.
  always_comb begin
    addr_adv = oS_addr;
    if (!mode_q) begin
      if (oS_addr != ADDR_LAST) addr_adv = oS_addr + AW'(1);
    end else begin
      if (oS_addr != '0) addr_adv = oS_addr - AW'(1);
    end
  end

  // Working registers, address, step counter and result/handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
      step_q  <= '0;
      oS_addr <= '0;
      oA      <= '0;
      oB      <= '0;
      oBusy   <= 1'b0;
      oDone   <= 1'b0;
    end else begin
      oDone <= 1'b0;
      if (accept) begin
        a_q     <= iA;
        b_q     <= iB;
        mode_q  <= iMode;
        step_q  <= '0;
        oS_addr <= iMode ? ADDR_LAST : '0;
        oBusy   <= 1'b1;
      end else if (state == PRIME) begin
        oS_addr <= addr_adv;
      end else if (state == RUN) begin
        a_q     <= a_nx;
        b_q     <= b_nx;
        oS_addr <= addr_adv;
        step_q  <= step_q + 9'd1;
        if (finish) begin
          oA     <= a_nx;
          oB     <= b_nx;
          oDone  <= 1'b1;
          oBusy  <= 1'b0;
          step_q <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rc5_round_core.sv
// tb_rc5_round_core: bench for rc5_round_core with three instances
// (RC5-32/12, RC5-16/4, RC5-64/12), each fed by its own synchronous S-table RAM.
module tb_rc5_round_core;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // instance 0: W=32 R=12
  logic        st0, md0, bz0, dn0;
  logic [31:0] a0, b0, sd0, oa0, ob0;
  logic [4:0]  ad0;
  // instance 1: W=16 R=4
  logic        st1, md1, bz1, dn1;
  logic [15:0] a1, b1, sd1, oa1, ob1;
  logic [3:0]  ad1;
  // instance 2: W=64 R=12
  logic        st2, md2, bz2, dn2;
  logic [63:0] a2, b2, sd2, oa2, ob2;
  logic [4:0]  ad2;

  logic [31:0] s0 [0:31];
  logic [15:0] s1 [0:15];
  logic [63:0] s2 [0:31];

  always @(posedge clk) sd0 <= s0[ad0];
  always @(posedge clk) sd1 <= s1[ad1];
  always @(posedge clk) sd2 <= s2[ad2];

  rc5_round_core #(.W(32), .LGW(5), .R(12), .AW(5)) u0 (
    .clk(clk), .rst(rst), .iStart(st0), .iMode(md0), .iA(a0), .iB(b0),
    .oS_addr(ad0), .iS_data(sd0), .oA(oa0), .oB(ob0), .oBusy(bz0), .oDone(dn0));
  rc5_round_core #(.W(16), .LGW(4), .R(4), .AW(4)) u1 (
    .clk(clk), .rst(rst), .iStart(st1), .iMode(md1), .iA(a1), .iB(b1),
    .oS_addr(ad1), .iS_data(sd1), .oA(oa1), .oB(ob1), .oBusy(bz1), .oDone(dn1));
  rc5_round_core #(.W(64), .LGW(6), .R(12), .AW(5)) u2 (
    .clk(clk), .rst(rst), .iStart(st2), .iMode(md2), .iA(a2), .iB(b2),
    .oS_addr(ad2), .iS_data(sd2), .oA(oa2), .oB(ob2), .oBusy(bz2), .oDone(dn2));

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q[$];
  logic [63:0] addr_q[$];
  logic [63:0] ms [0:31];

  typedef struct {
    int          inst;
    logic        mode;
    logic [63:0] a, b, ea, eb;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic int wid(input int inst);
    return (inst == 0) ? 32 : (inst == 1) ? 16 : 64;
  endfunction

  function automatic int rnd(input int inst);
    return (inst == 1) ? 4 : 12;
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [63:0] msk(input int w);
    if (w == 64) return '1;
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic int amt(input logic [63:0] x, input int w);
    return int'(x[5:0]) % w;
  endfunction

  function automatic logic [63:0] rotl(input logic [63:0] x_in, input int n, input int w);
    logic [63:0] x;
    int s;
    x = x_in & msk(w);
    s = n % w;
    if (s == 0) return x;
    return ((x << s) | (x >> (w - s))) & msk(w);
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] x_in, input int n, input int w);
    logic [63:0] x;
    int s;
    x = x_in & msk(w);
    s = n % w;
    if (s == 0) return x;
    return ((x >> s) | (x << (w - s))) & msk(w);
  endfunction

  task automatic load_ms(input int inst);
    for (int i = 0; i < 32; i++) begin
      if (inst == 0)      ms[i] = {32'd0, s0[i]};
      else if (inst == 1) ms[i] = (i < 16) ? {48'd0, s1[i]} : 64'd0;
      else                ms[i] = s2[i];
    end
  endtask

  task automatic model_enc(input int w, input int r, input logic [63:0] a_in, input logic [63:0] b_in,
                           output logic [63:0] a_o, output logic [63:0] b_o);
    logic [63:0] m, a, b;
    m = msk(w);
    a = (a_in + ms[0]) & m;
    b = (b_in + ms[1]) & m;
    for (int i = 1; i <= r; i++) begin
      a = (rotl(a ^ b, amt(b, w), w) + ms[2*i]) & m;
      b = (rotl(b ^ a, amt(a, w), w) + ms[2*i+1]) & m;
    end
    a_o = a;
    b_o = b;
  endtask

  task automatic model_dec(input int w, input int r, input logic [63:0] a_in, input logic [63:0] b_in,
                           output logic [63:0] a_o, output logic [63:0] b_o);
    logic [63:0] m, a, b;
    m = msk(w);
    a = a_in & m;
    b = b_in & m;
    for (int i = r; i >= 1; i--) begin
      b = rotr((b - ms[2*i+1]) & m, amt(a, w), w) ^ a;
      a = rotr((a - ms[2*i]) & m, amt(b, w), w) ^ b;
    end
    b = (b - ms[1]) & m;
    a = (a - ms[0]) & m;
    a_o = a;
    b_o = b;
  endtask

  // RC5-32/12/16 key expansion for an all-zero 16-byte key.
  task automatic zero_key_expand();
    logic [63:0] sk [0:25];
    logic [63:0] l [0:3];
    logic [63:0] ka, kb;
    int i, j;
    sk[0] = 64'hB7E15163;
    for (int n = 1; n < 26; n++) sk[n] = (sk[n-1] + 64'h9E3779B9) & 64'hFFFFFFFF;
    for (int n = 0; n < 4; n++) l[n] = 64'd0;
    ka = 0; kb = 0; i = 0; j = 0;
    for (int n = 0; n < 78; n++) begin
      ka = rotl((sk[i] + ka + kb) & 64'hFFFFFFFF, 3, 32);
      sk[i] = ka;
      kb = rotl((l[j] + ka + kb) & 64'hFFFFFFFF, int'((ka + kb) % 64'd32), 32);
      l[j] = kb;
      i = (i + 1) % 26;
      j = (j + 1) % 4;
    end
    for (int n = 0; n < 32; n++) s0[n] = (n < 26) ? sk[n][31:0] : 32'd0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_in(input int inst, input logic s, input logic m, input logic [63:0] a, input logic [63:0] b);
    case (inst)
      0: begin st0 = s; md0 = m; a0 = a[31:0]; b0 = b[31:0]; end
      1: begin st1 = s; md1 = m; a1 = a[15:0]; b1 = b[15:0]; end
      default: begin st2 = s; md2 = m; a2 = a; b2 = b; end
    endcase
  endtask

  task automatic get_out(input int inst, output logic dn, output logic bz,
                         output logic [63:0] oa, output logic [63:0] ob, output logic [63:0] addr);
    case (inst)
      0: begin dn = dn0; bz = bz0; oa = {32'd0, oa0}; ob = {32'd0, ob0}; addr = {59'd0, ad0}; end
      1: begin dn = dn1; bz = bz1; oa = {48'd0, oa1}; ob = {48'd0, ob1}; addr = {60'd0, ad1}; end
      default: begin dn = dn2; bz = bz2; oa = oa2; ob = ob2; addr = {59'd0, ad2}; end
    endcase
  endtask

  // One operation: start pulse, scramble inputs after the latch edge, wait
  // (bounded) for oDone, checking latency and busy along the way.
  task automatic run_op(input int inst, input logic m, input logic [63:0] a, input logic [63:0] b,
                        input string tag, output logic [63:0] ra, output logic [63:0] rb);
    logic dn, bz;
    logic [63:0] oa, ob, addr;
    int lat, bsy_bad, lim;
    lim = 2 * rnd(inst) + 3;
    addr_q.delete();
    @(negedge clk);
    set_in(inst, 1'b1, m, a, b);
    @(posedge clk);
    #1;
    set_in(inst, 1'b0, ~m, {$urandom(), $urandom()}, {$urandom(), $urandom()});
    get_out(inst, dn, bz, oa, ob, addr);
    addr_q.push_back(addr);
    bsy_bad = bz ? 0 : 1;
    lat = 0;
    while (lat < lim + 20) begin
      @(posedge clk);
      #1;
      lat++;
      get_out(inst, dn, bz, oa, ob, addr);
      addr_q.push_back(addr);
      if (dn) break;
      if (!bz) bsy_bad++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(lim));
    check({tag, "_busy_run"}, 64'(bsy_bad), 64'd0);
    check({tag, "_busy_done"}, {63'd0, bz}, 64'd0);
    ra = oa;
    rb = ob;
  endtask

  task automatic check_trace(input string tag);
    logic [63:0] e, g;
    int n;
    n = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (addr_q.size() > 0) ? addr_q.pop_front() : 64'hDEAD;
      check($sformatf("%s_addr%0d", tag, n), g, e);
      n++;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic dn, bz;
    logic [63:0] oa, ob, addr, ra, rb, xa, xb, ea, eb, pa, pb;
    int ndone, lat1, lat2, hold_bad;
    vec_t v;

    rst = 1'b1;
    set_in(0, 1'b0, 1'b0, 64'd0, 64'd0);
    set_in(1, 1'b0, 1'b0, 64'd0, 64'd0);
    set_in(2, 1'b0, 1'b0, 64'd0, 64'd0);
    zero_key_expand();
    for (int i = 0; i < 16; i++) s1[i] = (i < 10) ? 16'($urandom()) : 16'd0;
    for (int i = 0; i < 32; i++) s2[i] = (i < 26) ? {$urandom(), $urandom()} : 64'd0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      get_out(i, dn, bz, oa, ob, addr);
      check($sformatf("reset%0d_busy", i), {63'd0, bz}, 64'd0);
      check($sformatf("reset%0d_done", i), {63'd0, dn}, 64'd0);
      check($sformatf("reset%0d_oa", i), oa, 64'd0);
      check($sformatf("reset%0d_ob", i), ob, 64'd0);
      check($sformatf("reset%0d_addr", i), addr, 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    // ---- vector table ----
    vecs.push_back('{0, 1'b0, 64'h0, 64'h0, 64'hEEDBA521, 64'h6D8F4B15});
    vecs.push_back('{0, 1'b1, 64'hEEDBA521, 64'h6D8F4B15, 64'h0, 64'h0});
    load_ms(1);
    model_enc(16, 4, 64'h1234, 64'h0010, ea, eb);
    vecs.push_back('{1, 1'b0, 64'h1234, 64'h0010, ea, eb});
    vecs.push_back('{1, 1'b1, ea, eb, 64'h1234, 64'h0010});
    model_enc(16, 4, 64'hABCD, 64'h000F, ea, eb);
    vecs.push_back('{1, 1'b0, 64'hABCD, 64'h000F, ea, eb});
    load_ms(2);
    xa = {$urandom(), $urandom()};
    xb = {$urandom(), $urandom(), 6'h3F};
    model_enc(64, 12, xa, xb, ea, eb);
    vecs.push_back('{2, 1'b0, xa, xb, ea, eb});
    vecs.push_back('{2, 1'b1, ea, eb, xa, xb});

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      run_op(v.inst, v.mode, v.a, v.b, $sformatf("vec%0d", i), ra, rb);
      check($sformatf("vec%0d_a", i), ra, v.ea);
      check($sformatf("vec%0d_b", i), rb, v.eb);
    end

    // ---- address traces on the 32-bit instance ----
    run_op(0, 1'b0, 64'h0, 64'h0, "enc_trace", ra, rb);
    for (int i = 0; i <= 25; i++) exp_q.push_back(64'(i));
    check_trace("enc_trace");
    run_op(0, 1'b1, 64'hEEDBA521, 64'h6D8F4B15, "dec_trace", ra, rb);
    for (int i = 25; i >= 0; i--) exp_q.push_back(64'(i));
    check_trace("dec_trace");
    check("dec_trace_a", ra, 64'h0);
    check("dec_trace_b", rb, 64'h0);

    // ---- back-to-back with a stray start mid-run ----
    load_ms(0);
    pa = {32'd0, $urandom()};
    pb = {32'd0, $urandom()};
    model_enc(32, 12, pa, pb, ea, eb);
    @(negedge clk);
    set_in(0, 1'b1, 1'b0, pa, pb);
    @(posedge clk);
    #1;
    set_in(0, 1'b0, 1'b1, 64'd0, 64'd0);
    ndone = 0; lat1 = 0; lat2 = 0; hold_bad = 0; ra = 0; rb = 0;
    for (int cyc = 1; cyc <= 120; cyc++) begin
      @(posedge clk);
      #1;
      get_out(0, dn, bz, oa, ob, addr);
      if (dn) begin
        ndone++;
        if (ndone == 1) begin lat1 = cyc; ra = oa; rb = ob; end
        else if (ndone == 2) lat2 = cyc;
      end
      if (ndone == 1 && !dn && (oa != ra || ob != rb)) hold_bad++;
      if (dn && ndone == 1)         set_in(0, 1'b1, 1'b1, ra, rb);
      else if (cyc == 10 || cyc == 40) set_in(0, 1'b1, 1'b0, {$urandom(), $urandom()}, {$urandom(), $urandom()});
      else                          set_in(0, 1'b0, 1'b0, {$urandom(), $urandom()}, {$urandom(), $urandom()});
    end
    set_in(0, 1'b0, 1'b0, 64'd0, 64'd0);
    check("b2b_done_count", 64'(ndone), 64'd2);
    check("b2b_lat1", 64'(lat1), 64'd27);
    check("b2b_lat2", 64'(lat2), 64'd55);
    check("b2b_enc_a", ra, ea);
    check("b2b_enc_b", rb, eb);
    check("b2b_hold", 64'(hold_bad), 64'd0);
    check("b2b_plain_a", oa, pa);
    check("b2b_plain_b", ob, pb);

    // ---- randomized RC5-16/4 round trips ----
    load_ms(1);
    for (int n = 0; n < 100; n++) begin
      xa = {48'd0, 16'($urandom())};
      xb = {48'd0, 16'($urandom())};
      model_enc(16, 4, xa, xb, ea, eb);
      run_op(1, 1'b0, xa, xb, $sformatf("r16e%0d", n), ra, rb);
      check($sformatf("r16e%0d_a", n), ra, ea);
      check($sformatf("r16e%0d_b", n), rb, eb);
      run_op(1, 1'b1, ra, rb, $sformatf("r16d%0d", n), ra, rb);
      check($sformatf("r16d%0d_a", n), ra, xa);
      check($sformatf("r16d%0d_b", n), rb, xb);
    end

    // ---- randomized RC5-64/12 against the model ----
    load_ms(2);
    for (int n = 0; n < 100; n++) begin
      xa = {$urandom(), $urandom()};
      xb = {$urandom(), $urandom()};
      if (n % 10 == 0) xb[5:0] = 6'h3F;
      model_enc(64, 12, xa, xb, ea, eb);
      run_op(2, 1'b0, xa, xb, $sformatf("r64e%0d", n), ra, rb);
      check($sformatf("r64e%0d_a", n), ra, ea);
      check($sformatf("r64e%0d_b", n), rb, eb);
      model_dec(64, 12, xa, xb, ea, eb);
      run_op(2, 1'b1, xa, xb, $sformatf("r64d%0d", n), ra, rb);
      check($sformatf("r64d%0d_a", n), ra, ea);
      check($sformatf("r64d%0d_b", n), rb, eb);
    end

    // ---- reset in the middle of a run ----
    @(negedge clk);
    set_in(0, 1'b1, 1'b0, 64'h1111, 64'h2222);
    @(posedge clk);
    #1;
    set_in(0, 1'b0, 1'b0, 64'd0, 64'd0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    get_out(0, dn, bz, oa, ob, addr);
    check("rst_busy", {63'd0, bz}, 64'd0);
    check("rst_done", {63'd0, dn}, 64'd0);
    check("rst_oa", oa, 64'd0);
    check("rst_ob", ob, 64'd0);
    check("rst_addr", addr, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk);
      #1;
      if (dn0) ndone++;
    end
    check("rst_no_done", 64'(ndone), 64'd0);
    run_op(0, 1'b0, 64'h0, 64'h0, "post_rst", ra, rb);
    check("post_rst_a", ra, 64'hEEDBA521);
    check("post_rst_b", rb, 64'h6D8F4B15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
